// File: rtl/signext_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : signext_pkg
//  Description : Shared types for the pipelined immediate extender: the
//                extension-mode encoding used on the decode interface and the
//                occupancy states of the two-entry output skid buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package signext_pkg;

    // Encoding is fixed by the decode stage that drives in_mode.
    typedef enum logic [1:0] {
        EXT_SIGN      = 2'd0,
        EXT_ZERO      = 2'd1,
        EXT_UPPER     = 2'd2,
        EXT_SIGN_SHL2 = 2'd3
    } ext_mode_t;

    // Number of results currently held: none, main only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage : signext_pkg
`default_nettype wire

// File: rtl/signext_core.sv
`default_nettype none
// ============================================================================
//  Module      : signext_core
//  Description : Purely combinational extension mux. Widens an IN_W-bit
//                immediate to OUT_W bits as sign, zero, upper (immediate in
//                the MSBs) or sign-extend followed by a left shift of two.
//  Ports       : i_data  [IN_W-1:0]  raw immediate
//                i_mode  ext_mode_t  extension selector
//                o_data  [OUT_W-1:0] extended value
//  Revision    : 1.0  initial release
// ============================================================================
module signext_core
    import signext_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_data,
    input  ext_mode_t        i_mode,
    output logic [OUT_W-1:0] o_data
);

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_shl2;

    assign w_sext  = {{(OUT_W-IN_W){i_data[IN_W-1]}}, i_data};
    assign w_zext  = {{(OUT_W-IN_W){1'b0}}, i_data};
    assign w_upper = {i_data, {(OUT_W-IN_W){1'b0}}};
    // Branch-offset form: word offset converted to a byte offset; the two
    // bits shifted out of the top are simply dropped.
    assign w_shl2  = {w_sext[OUT_W-3:0], 2'b00};

    always_comb begin
        o_data = w_sext;
        case (i_mode)
            EXT_SIGN:      o_data = w_sext;
            EXT_ZERO:      o_data = w_zext;
            EXT_UPPER:     o_data = w_upper;
            EXT_SIGN_SHL2: o_data = w_shl2;
            default:       o_data = w_sext;
        endcase
    end

endmodule : signext_core
`default_nettype wire

// File: rtl/signext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : signext_pipe
//  Description : Pipelined immediate extender with valid/ready handshakes on
//                both sides. The extension is computed on the accept cycle
//                and stored in a two-entry skid buffer (main + skid) so the
//                block sustains one transfer per cycle under backpressure
//                while in_ready stays a pure flop.
//  Ports       : clk, reset             clock, synchronous active-high reset
//                in_valid/in_ready      upstream handshake
//                in_data [IN_W-1:0]     raw immediate
//                in_mode [1:0]          ext_mode_t selector
//                out_valid/out_ready    downstream handshake
//                out_data [OUT_W-1:0]   extended immediate
//                out_count [7:0]        completed output transfers (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module signext_pipe
    import signext_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [7:0]       out_count
);

    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_deliver;

    buf_state_t       r_state;
    logic [OUT_W-1:0] r_main;
    logic [OUT_W-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [7:0]       r_count;

    signext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_data (in_data),
        .i_mode (ext_mode_t'(in_mode)),
        .o_data (w_ext)
    );

    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = r_out_valid & out_ready;

    // in_ready and out_valid are updated alongside the state so that each
    // always equals a decode of the state it is registered with; in_ready
    // never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_count     <= 8'd0;
        end else begin
            if (w_deliver) begin
                r_count <= r_count + 8'd1;
            end

            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main      <= w_ext;
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && out_ready) begin
                        r_main <= w_ext;
                    end else if (w_accept) begin
                        // Main is stalled; park the newcomer behind it.
                        r_skid     <= w_ext;
                        r_state    <= FULL;
                        r_in_ready <= 1'b0;
                    end else if (out_ready) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (out_ready) begin
                        r_main     <= r_skid;
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign out_count = r_count;

endmodule : signext_pipe
`default_nettype wire

// File: tb/tb_signext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signext_pipe
//  Description : Scoreboard bench for signext_pipe (IN_W=4, OUT_W=16).
//                Accepted inputs push an arithmetically derived expected
//                result; a negedge monitor pops and compares on every output
//                transfer and tracks out_count and output stability.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_signext_pipe;

    localparam int IW = 4;
    localparam int OW = 16;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [7:0]    out_count;

    int            errors;
    int            checks;
    int            stalls;
    logic [7:0]    model_cnt;
    logic [OW-1:0] q[$];
    logic          prev_hold;
    logic [OW-1:0] prev_data;
    logic          bp_done;

    signext_pipe #(.IN_W(IW), .OUT_W(OW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret the immediate as a number, apply the mode as
    // arithmetic, and reduce modulo 2**OW.
    function automatic logic [OW-1:0] ref_ext(input int x, input int m);
        int s;
        int r;
        s = (x >= (1 << (IW-1))) ? x - (1 << IW) : x;
        case (m)
            0:       r = s;
            1:       r = x;
            2:       r = x * (1 << (OW-IW));
            default: r = s * 4;
        endcase
        return OW'(r & ((1 << OW) - 1));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            model_cnt = 8'd0;
            prev_hold = 1'b0;
        end else begin
            checks++;
            if (out_count !== model_cnt) begin
                errors++;
                $display("FAIL out_count: got %0d expected %0d at %0t", out_count, model_cnt, $time);
            end
            if (prev_hold) begin
                checks++;
                if (!out_valid || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold: valid=%0b data=0x%0h expected data=0x%0h at %0t",
                             out_valid, out_data, prev_data, $time);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got 0x%0h expected none at %0t", out_data, $time);
                end else begin
                    logic [OW-1:0] e;
                    e = q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL data: got 0x%0h expected 0x%0h at %0t", out_data, e, $time);
                    end
                end
                model_cnt = model_cnt + 8'd1;
            end
            if (in_valid && in_ready)
                q.push_back(ref_ext(int'(in_data), int'(in_mode)));
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [IW-1:0] d, input logic [1:0] m);
        int n;
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 expected 1 after %0d cycles", n);
        end
        stalls += n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding expected 0", q.size());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic direct(input string name, input logic [IW-1:0] d,
                          input logic [1:0] m, input logic [OW-1:0] exp);
        send(d, m);
        @(negedge clk);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk(name, int'(out_data), int'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        errors    = 0;
        checks    = 0;
        stalls    = 0;
        model_cnt = 8'd0;
        prev_hold = 1'b0;
        prev_data = '0;
        bp_done   = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_count", int'(out_count), 0);
        @(posedge clk);
        #1;

        // T1 / T2: every mode, negative and positive immediates
        direct("t1_sign",  4'b1010, 2'd0, 16'hFFFA);
        direct("t1_zero",  4'b1010, 2'd1, 16'h000A);
        direct("t1_upper", 4'b1010, 2'd2, 16'hA000);
        direct("t1_shl2",  4'b1010, 2'd3, 16'hFFE8);
        direct("t2_sign",  4'b0111, 2'd0, 16'h0007);
        direct("t2_shl2",  4'b0111, 2'd3, 16'h001C);
        drain();

        // T3: backpressure fills both entries, then drains in order
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        a = IW'($urandom);
        b = IW'($urandom);
        send(a, 2'd0);
        send(b, 2'd3);
        @(negedge clk);
        chk("t3_in_ready_full", int'(in_ready), 0);
        chk("t3_head", int'(out_data), int'(ref_ext(int'(a), 0)));
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 3; i++)
                    send(IW'($urandom), 2'($urandom));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // T4: back-to-back streaming from a fresh count
        do_reset();
        stalls = 0;
        for (int i = 0; i < 20; i++)
            send(IW'($urandom), 2'($urandom));
        chk("t4_no_stall", stalls, 0);
        drain();
        chk("t4_out_count", int'(out_count), 20);

        // Random backpressure
        @(posedge clk);
        #1;
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++)
                    send(IW'($urandom), 2'($urandom));
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // T5: reset while FULL discards both entries
        do_reset();
        out_ready = 1'b0;
        send(IW'($urandom), 2'd1);
        send(IW'($urandom), 2'd2);
        @(negedge clk);
        chk("t5_full", int'(in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_out_valid", int'(out_valid), 0);
        chk("t5_in_ready", int'(in_ready), 1);
        chk("t5_out_count", int'(out_count), 0);
        @(posedge clk);
        #1;
        send(4'hC, 2'd0);
        drain();

        // T6: out_count wraps after 256 transfers
        do_reset();
        for (int i = 0; i < 255; i++)
            send(IW'($urandom), 2'($urandom));
        drain();
        chk("t6_count_255", int'(out_count), 255);
        @(posedge clk);
        #1;
        send(IW'($urandom), 2'($urandom));
        drain();
        chk("t6_count_wrap", int'(out_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_signext_pipe
`default_nettype wire
